req_fifo_mbuf: RTL and testbench



---
 rtl/req_buf_pkg.sv | 11 +
 rtl/req_fifo_ram.sv | 27 ++
 rtl/req_fifo_mbuf.sv | 151 +++++++++++++++
 tb/tb_req_fifo_mbuf.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/req_buf_pkg.sv
// Shared request-buffer definitions: the default end-of-request marker and the EOR detector.
package req_buf_pkg;

    localparam logic [7:0] DELIM_DEFAULT = 8'hee;

    // A word ends a request when its top byte carries the delimiter.
    function automatic logic is_eor(input logic [7:0] top_byte, input logic [7:0] delim);
        return (top_byte == delim);
    endfunction

endpackage

// File: rtl/req_fifo_ram.sv
// Storage array for the request FIFO: synchronous write, asynchronous (show-ahead) read.
module req_fifo_ram #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned ENTRIES = 1 << DEPTH;

    logic [WIDTH-1:0] mem_q [ENTRIES];

    // Contents are deliberately left unreset; validity is tracked by the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/req_fifo_mbuf.sv
// Request FIFO with exact occupancy, programmable thresholds, sticky errors and EOR request counting.
module req_fifo_mbuf
    import req_buf_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 1,
    parameter logic [7:0]  DELIM     = DELIM_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             rd,
    output logic [WIDTH-1:0] r_data,
    output logic             r_eor,
    input  logic             flush,
    input  logic             clr_err,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [DEPTH:0]   count,
    output logic [DEPTH:0]   space,
    output logic [DEPTH:0]   req_cnt,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned ENTRIES = 1 << DEPTH;
    localparam int unsigned CW      = DEPTH + 1;

    logic [DEPTH-1:0] w_ptr_q, w_ptr_d;
    logic [DEPTH-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    space_q, space_d;
    logic [CW-1:0]    req_cnt_q, req_cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rd_acc, wr_acc, w_eor, mem_we, ovf_evt, unf_evt;
    logic [WIDTH:0]   head_word;
    logic             head_eor;

    req_fifo_ram #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_ptr_q),
        .wdata ({w_eor, w_data}),
        .raddr (r_ptr_q),
        .rdata (head_word)
    );

    assign head_eor = head_word[WIDTH];

    // Acceptance, pointer/counter updates and count-derived flags.
    always_comb begin
        rd_acc      = rd & ~empty_q;
        wr_acc      = wr & (~full_q | rd_acc);
        w_eor       = is_eor(w_data[WIDTH-1 -: 8], DELIM);
        mem_we      = 1'b0;
        ovf_evt     = 1'b0;
        unf_evt     = 1'b0;
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        req_cnt_d   = req_cnt_q;

        if (flush) begin
            w_ptr_d   = '0;
            r_ptr_d   = '0;
            count_d   = '0;
            req_cnt_d = '0;
        end else begin
            mem_we  = wr_acc;
            ovf_evt = wr & ~wr_acc;
            unf_evt = rd & empty_q;
            if (wr_acc) begin
                w_ptr_d = w_ptr_q + DEPTH'(1);
            end
            if (rd_acc) begin
                r_ptr_d = r_ptr_q + DEPTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            req_cnt_d = req_cnt_q + CW'(wr_acc & w_eor) - CW'(rd_acc & head_eor);
        end

        // A fresh error in the same cycle as clr_err wins.
        overflow_d  = ovf_evt | (overflow_q & ~clr_err);
        underflow_d = unf_evt | (underflow_q & ~clr_err);

        empty_d = (count_d == '0);
        full_d  = (32'(count_d) == ENTRIES);
        af_d    = (32'(count_d) >= AF_THRESH);
        ae_d    = (32'(count_d) <= AE_THRESH);
        space_d = CW'(ENTRIES) - count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            space_q     <= CW'(ENTRIES);
            req_cnt_q   <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            space_q     <= space_d;
            req_cnt_q   <= req_cnt_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign r_data       = head_word[WIDTH-1:0];
    assign r_eor        = head_eor;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign space        = space_q;
    assign req_cnt      = req_cnt_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_req_fifo_mbuf.sv
// Bench for req_fifo_mbuf: directed and random traffic against a queue-based reference model.
module tb_req_fifo_mbuf;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned AF      = 6;
    localparam int unsigned AE      = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr, rd, flush, clr_err;
    logic [63:0] w_data;
    logic [63:0] r_data;
    logic        r_eor, empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count, space, req_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [63:0] model_q[$];
    logic        m_ovf, m_unf;

    req_fifo_mbuf dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .r_eor        (r_eor),
        .flush        (flush),
        .clr_err      (clr_err),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .space        (space),
        .req_cnt      (req_cnt),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int model_reqs();
        int n = 0;
        foreach (model_q[i]) if (model_q[i][63:56] == 8'hee) n++;
        return n;
    endfunction

    task automatic check_all(input string tag);
        int n = model_q.size();
        chk({tag, ".count"},   64'(count),        64'(n));
        chk({tag, ".space"},   64'(space),        64'(ENTRIES - n));
        chk({tag, ".empty"},   64'(empty),        64'(n == 0));
        chk({tag, ".full"},    64'(full),         64'(n == ENTRIES));
        chk({tag, ".afull"},   64'(almost_full),  64'(n >= AF));
        chk({tag, ".aempty"},  64'(almost_empty), 64'(n <= AE));
        chk({tag, ".req_cnt"}, 64'(req_cnt),      64'(model_reqs()));
        chk({tag, ".ovf"},     64'(overflow),     64'(m_ovf));
        chk({tag, ".unf"},     64'(underflow),    64'(m_unf));
        if (n > 0) begin
            chk({tag, ".r_data"}, r_data,       model_q[0]);
            chk({tag, ".r_eor"},  64'(r_eor),   64'(model_q[0][63:56] == 8'hee));
        end
    endtask

    // Reference behaviour of one clock edge, expressed on the word queue.
    task automatic model_edge(input logic w, input logic [63:0] d, input logic r,
                              input logic f, input logic c);
        bit had = (model_q.size() > 0);
        bit ra, wa, oe, ue;
        if (f) begin
            model_q.delete();
            oe = 0;
            ue = 0;
        end else begin
            ra = r && had;
            wa = w && (model_q.size() < ENTRIES || ra);
            oe = w && !wa;
            ue = r && !had;
            if (ra) void'(model_q.pop_front());
            if (wa) model_q.push_back(d);
        end
        m_ovf = oe ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = ue ? 1'b1 : (c ? 1'b0 : m_unf);
    endtask

    task automatic step(input logic w, input logic [63:0] d, input logic r,
                        input logic f, input logic c, input string tag);
        wr = w; w_data = d; rd = r; flush = f; clr_err = c;
        @(posedge clk);
        model_edge(w, d, r, f, c);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic logic [63:0] rnd_word(input bit eor);
        logic [63:0] v = {$urandom, $urandom};
        if (eor) v[63:56] = 8'hee;
        else if (v[63:56] == 8'hee) v[63:56] = 8'h11;
        return v;
    endfunction

    initial begin
        logic [63:0] d;
        rst_n = 1'b0; wr = 0; rd = 0; flush = 0; clr_err = 0; w_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Fill with plain words, then overflow.
        for (int i = 1; i <= 8; i++) step(1, 64'(i), 0, 0, 0, "fill");
        chk("fill8.full", 64'(full), 64'd1);
        chk("fill8.space", 64'(space), 64'd0);
        step(1, 64'h99, 0, 0, 0, "ovf_wr");
        chk("ovf_wr.overflow", 64'(overflow), 64'd1);
        chk("ovf_wr.count", 64'(count), 64'd8);

        // Drain in order, underflow, then clear.
        for (int i = 1; i <= 8; i++) begin
            chk("drain.order", r_data, 64'(i));
            step(0, '0, 1, 0, 0, "drain");
        end
        step(0, '0, 1, 0, 0, "unf_rd");
        chk("unf_rd.underflow", 64'(underflow), 64'd1);
        step(0, '0, 0, 0, 1, "clr_err");
        chk("clr_err.underflow", 64'(underflow), 64'd0);

        // Request framing.
        step(1, 64'hEE00_0000_0000_0001, 0, 0, 0, "frame_w");
        step(1, 64'h1234, 0, 0, 0, "frame_w");
        step(1, 64'hEE00_0000_0000_0002, 0, 0, 0, "frame_w");
        chk("frame.req_cnt", 64'(req_cnt), 64'd2);
        chk("frame.r_eor", 64'(r_eor), 64'd1);
        step(0, '0, 1, 0, 0, "frame_r");
        chk("frame.req_after1", 64'(req_cnt), 64'd1);
        step(0, '0, 1, 0, 0, "frame_r");
        step(0, '0, 1, 0, 0, "frame_r");
        chk("frame.req_after3", 64'(req_cnt), 64'd0);

        // Simultaneous rd&wr at full through two pointer wraps.
        for (int i = 0; i < 8; i++) step(1, rnd_word(i % 3 == 0), 0, 0, 0, "refill");
        for (int i = 0; i < 20; i++) step(1, rnd_word($urandom_range(0, 2) == 0), 1, 0, 0, "full_rw");
        chk("full_rw.count", 64'(count), 64'd8);
        chk("full_rw.overflow", 64'(overflow), 64'd0);

        // rd&wr on empty.
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0, "drain2");
        step(1, 64'hAA, 1, 0, 0, "rw_empty");
        chk("rw_empty.count", 64'(count), 64'd1);
        chk("rw_empty.r_data", r_data, 64'hAA);
        chk("rw_empty.underflow", 64'(underflow), 64'd1);

        // Flush beats a concurrent write and keeps sticky flags.
        for (int i = 0; i < 4; i++) step(1, rnd_word(i == 1), 0, 0, 0, "pre_flush");
        step(1, 64'h55, 0, 1, 0, "flush");
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.underflow", 64'(underflow), 64'd1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            d = rnd_word($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 15) == 0), "rand");
        end

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 5; i++) step(1, rnd_word(i == 2), 0, 0, 0, "burst");
        wr = 1; rd = 1; w_data = 64'hEE00_0000_0000_00FF;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("rst_async");
        @(posedge clk);
        @(negedge clk);
        check_all("rst_held");
        rst_n = 1'b1;
        step(1, 64'hEE00_0000_0000_0077, 0, 0, 0, "post_rst");
        chk("post_rst.count", 64'(count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
